// File: rtl/storage_controller_pkg.sv
// Shared definitions for the storage controller: FSM states, default flash
// read opcode and the internal SRAM address width.
package storage_controller_pkg;

  localparam int         SRAM_AW     = 11;
  localparam logic [7:0] READ_OPCODE = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    SRAM_ACC,
    SPI_CMD,
    SPI_DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_read_master.sv
// Mode-0 SPI master for one flash read: shifts out opcode plus 24-bit address,
// then shifts in 32 data bits MSB first. SCK is derived from clk by CLK_DIV.
module spi_read_master #(
  parameter int         CLK_DIV = 2,
  parameter logic [7:0] OPCODE  = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic        miso,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  output logic        cmd_done,
  output logic        done,
  output logic [31:0] rx_data
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DW-1:0] div_cnt;
  logic [6:0]    rise_cnt;
  logic [31:0]   tx_q;
  logic          busy;
  logic          finish;

  // One extra cycle after the final SCK fall keeps cs_n high before done is
  // reported, giving a fixed 64*CLK_DIV+2 cycle flash read latency overall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      rise_cnt <= '0;
      tx_q     <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
    end else if (abort) begin
      div_cnt  <= '0;
      rise_cnt <= '0;
      tx_q     <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
    end else if (start) begin
      div_cnt  <= '0;
      rise_cnt <= '0;
      tx_q     <= {OPCODE, flash_addr};
      rx_data  <= '0;
      busy     <= 1'b1;
      finish   <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b0;
      sck      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (finish) begin
        finish <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b1;
      end else if (busy) begin
        if (div_cnt == DW'(HALF - 1)) begin
          div_cnt <= '0;
          if (!sck) begin
            sck      <= 1'b1;
            rise_cnt <= rise_cnt + 7'd1;
            if (rise_cnt >= 7'd32)
              rx_data <= {rx_data[30:0], miso};
          end else begin
            sck  <= 1'b0;
            tx_q <= {tx_q[30:0], 1'b0};
            if (rise_cnt == 7'd64) begin
              cs_n   <= 1'b1;
              finish <= 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

  assign mosi     = tx_q[31];
  assign cmd_done = (rise_cnt >= 7'd32);

endmodule

// File: rtl/storage_controller.sv
// Memory controller: internal SRAM below SRAM_WORDS, read-only SPI flash above,
// plus a raw SPI passthrough so an external programmer can reach the flash.
module storage_controller #(
  parameter int         SRAM_WORDS  = 2048,
  parameter int         SPI_CLK_DIV = 2,
  parameter logic [7:0] READ_OPCODE = storage_controller_pkg::READ_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_access,
  input  logic        memory_is_writing,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic [3:0]  mem_be,
  output logic [31:0] d_out,
  output logic        out_valid,
  input  logic        set_programming_mode,
  output logic        external_storage_spi_cs_n,
  output logic        external_storage_spi_sck,
  output logic        external_storage_spi_mosi,
  input  logic        external_storage_spi_miso,
  input  logic        programming_spi_cs_n,
  input  logic        programming_spi_sck,
  input  logic        programming_spi_mosi,
  output logic        programming_spi_miso
);

  import storage_controller_pkg::*;

  state_t             state_q, state_d;
  logic               accept, spi_start;
  logic               sel_sram;
  logic               we_q, sram_hit_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [SRAM_AW-1:0] sram_idx_q;
  logic [23:0]        flash_addr_q;
  logic [31:0]        mem [SRAM_WORDS];

  logic        spi_cs_n, spi_sck, spi_mosi, spi_cmd_done, spi_done;
  logic [31:0] spi_rx;

  assign sel_sram = (addr < 32'(SRAM_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Flash-region writes take the SRAM path so they are acknowledged the same
  // way but never touch the array; only flash reads go out over SPI.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    spi_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (memory_access) begin
          accept = 1'b1;
          if (sel_sram || memory_is_writing) begin
            state_d = SRAM_ACC;
          end else begin
            state_d   = SPI_CMD;
            spi_start = 1'b1;
          end
        end
      end
      SRAM_ACC: state_d = DONE;
      SPI_CMD:  if (spi_cmd_done) state_d = SPI_DATA;
      SPI_DATA: if (spi_done) state_d = DONE;
      DONE:     if (!memory_access) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (set_programming_mode) begin
      state_d   = IDLE;
      accept    = 1'b0;
      spi_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      sram_hit_q   <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      sram_idx_q   <= '0;
      flash_addr_q <= '0;
    end else if (accept) begin
      we_q         <= memory_is_writing;
      sram_hit_q   <= sel_sram;
      wdata_q      <= d_in;
      be_q         <= mem_be;
      sram_idx_q   <= addr[SRAM_AW-1:0];
      flash_addr_q <= addr[23:0];
    end
  end

  // The array has no reset so it can map onto block RAM and survive resets.
  always_ff @(posedge clk) begin
    if (state_q == SRAM_ACC && we_q && sram_hit_q && !set_programming_mode) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b])
          mem[sram_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out <= '0;
    end else if (!set_programming_mode) begin
      if (state_q == SRAM_ACC && !we_q && sram_hit_q)
        d_out <= mem[sram_idx_q];
      else if (state_q == SPI_DATA && spi_done)
        d_out <= spi_rx;
    end
  end

  assign out_valid = (state_q == DONE) && !set_programming_mode;

  spi_read_master #(
    .CLK_DIV (SPI_CLK_DIV),
    .OPCODE  (READ_OPCODE)
  ) u_spi (
    .clk        (clk),
    .rst        (rst),
    .abort      (set_programming_mode),
    .start      (spi_start),
    .flash_addr (addr[23:0]),
    .miso       (external_storage_spi_miso),
    .cs_n       (spi_cs_n),
    .sck        (spi_sck),
    .mosi       (spi_mosi),
    .cmd_done   (spi_cmd_done),
    .done       (spi_done),
    .rx_data    (spi_rx)
  );

  assign external_storage_spi_cs_n = set_programming_mode ? programming_spi_cs_n : spi_cs_n;
  assign external_storage_spi_sck  = set_programming_mode ? programming_spi_sck  : spi_sck;
  assign external_storage_spi_mosi = set_programming_mode ? programming_spi_mosi : spi_mosi;
  assign programming_spi_miso      = set_programming_mode & external_storage_spi_miso;

endmodule

// File: tb/tb_storage_controller.sv
// Directed bench for storage_controller with a small mode-0 SPI flash model
// answering every read with 0x12345678.
module tb_storage_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_access;
  logic        memory_is_writing;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [3:0]  mem_be;
  logic [31:0] d_out;
  logic        out_valid;
  logic        set_programming_mode;
  logic        ext_cs_n, ext_sck, ext_mosi, ext_miso;
  logic        prog_cs_n, prog_sck, prog_mosi, prog_miso;

  logic        tb_miso_en = 1'b0;
  logic        tb_miso    = 1'b0;
  logic        slv_miso   = 1'b0;
  logic [6:0]  slv_cnt    = '0;
  logic [63:0] slv_cap    = '0;
  logic [31:0] slv_resp   = 32'h12345678;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int lat;

  storage_controller dut (
    .clk                       (clk),
    .rst                       (rst),
    .memory_access             (memory_access),
    .memory_is_writing         (memory_is_writing),
    .addr                      (addr),
    .d_in                      (d_in),
    .mem_be                    (mem_be),
    .d_out                     (d_out),
    .out_valid                 (out_valid),
    .set_programming_mode      (set_programming_mode),
    .external_storage_spi_cs_n (ext_cs_n),
    .external_storage_spi_sck  (ext_sck),
    .external_storage_spi_mosi (ext_mosi),
    .external_storage_spi_miso (ext_miso),
    .programming_spi_cs_n      (prog_cs_n),
    .programming_spi_sck       (prog_sck),
    .programming_spi_mosi      (prog_mosi),
    .programming_spi_miso      (prog_miso)
  );

  always #5 clk = ~clk;

  assign ext_miso = tb_miso_en ? tb_miso : slv_miso;

  // Flash model: capture MOSI on SCK rise, present data after SCK fall.
  always @(posedge ext_sck or posedge ext_cs_n) begin
    if (ext_cs_n) begin
      slv_cnt = '0;
    end else begin
      slv_cap = {slv_cap[62:0], ext_mosi};
      slv_cnt = slv_cnt + 7'd1;
    end
  end

  always @(negedge ext_sck) begin
    if (!ext_cs_n && slv_cnt >= 7'd32 && slv_cnt < 7'd64)
      slv_miso = slv_resp[63 - int'(slv_cnt)];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request and waits (bounded) for out_valid; lat counts posedges
  // from the accepting edge to the edge that raised out_valid.
  task automatic applyStimulus(input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               output int lat_o);
    @(negedge clk);
    memory_is_writing = we;
    addr              = a;
    d_in              = d;
    mem_be            = be;
    memory_access     = 1'b1;
    lat_o             = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat_o = c - 1;
        break;
      end
    end
    checkOutput($sformatf("out_valid a=%h", a), 32'(out_valid), 32'd1);
    memory_access = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst                  = 1'b1;
    memory_access        = 1'b0;
    memory_is_writing    = 1'b0;
    addr                 = '0;
    d_in                 = '0;
    mem_be               = '0;
    set_programming_mode = 1'b0;
    prog_cs_n            = 1'b1;
    prog_sck             = 1'b0;
    prog_mosi            = 1'b0;

    #1;
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst d_out",     d_out,          32'd0);
    checkOutput("rst cs_n",      32'(ext_cs_n),  32'd1);
    checkOutput("rst sck",       32'(ext_sck),   32'd0);
    checkOutput("rst mosi",      32'(ext_mosi),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Passthrough
    set_programming_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {prog_cs_n, prog_sck, prog_mosi} = v;
      #1;
      checkOutput($sformatf("pass pins %0d", i),
                  32'({ext_cs_n, ext_sck, ext_mosi}), 32'(v));
    end
    checkOutput("pass out_valid", 32'(out_valid), 32'd0);
    tb_miso_en = 1'b1;
    tb_miso    = 1'b0;
    #1 checkOutput("pass miso0", 32'(prog_miso), 32'd0);
    tb_miso = 1'b1;
    #1 checkOutput("pass miso1", 32'(prog_miso), 32'd1);
    {prog_cs_n, prog_sck, prog_mosi} = 3'b100;
    @(negedge clk);
    set_programming_mode = 1'b0;
    #1;
    checkOutput("normal prog_miso", 32'(prog_miso), 32'd0);
    checkOutput("normal cs_n",      32'(ext_cs_n),  32'd1);
    tb_miso_en = 1'b0;

    // SRAM sweep
    for (int i = 0; i < 2048; i++) applyStimulus(1'b1, 32'(i), 32'(i), 4'hF, lat);
    checkOutput("sram write lat", 32'(lat), 32'd1);
    for (int i = 0; i < 2048; i++) begin
      applyStimulus(1'b0, 32'(i), 32'd0, 4'h0, lat);
      checkOutput($sformatf("sram rd %h", i), d_out, 32'(i));
    end
    checkOutput("sram read lat", 32'(lat), 32'd1);

    // Byte enables
    applyStimulus(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, lat);
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 4'b0101, lat);
    applyStimulus(1'b0, 32'h20, 32'd0, 4'h0, lat);
    checkOutput("byte enable", d_out, 32'hFF34_FF78);

    // Flash-region write is acknowledged but ignored, and must not alias SRAM
    applyStimulus(1'b1, 32'h800, 32'hDEAD_BEEF, 4'hF, lat);
    checkOutput("flash wr lat",  32'(lat),      32'd1);
    checkOutput("flash wr cs_n", 32'(ext_cs_n), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'd0, 4'h0, lat);
    checkOutput("no alias", d_out, 32'h0);
    applyStimulus(1'b0, 32'h7FF, 32'd0, 4'h0, lat);
    checkOutput("sram top", d_out, 32'h7FF);

    // Flash read
    applyStimulus(1'b0, 32'h0000_1001, 32'd0, 4'h0, lat);
    checkOutput("flash cmd",  slv_cap[63:32], 32'h0300_1001);
    checkOutput("flash data", d_out,          32'h1234_5678);
    checkOutput("flash lat",  32'(lat),       32'd130);
    checkOutput("flash cs_n", 32'(ext_cs_n),  32'd1);
    @(negedge clk);
    checkOutput("done->idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a flash read
    @(negedge clk);
    memory_is_writing = 1'b0;
    addr              = 32'h0000_2000;
    memory_access     = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (slv_cnt >= 7'd10) break;
    end
    checkOutput("reached 10 edges", 32'(slv_cnt >= 7'd10), 32'd1);
    checkOutput("mid cs_n low", 32'(ext_cs_n), 32'd0);
    #2;
    rst           = 1'b1;
    memory_access = 1'b0;
    #1;
    checkOutput("abort cs_n",      32'(ext_cs_n),  32'd1);
    checkOutput("abort sck",       32'(ext_sck),   32'd0);
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort d_out", d_out, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, lat);
    checkOutput("post-abort rd", d_out, 32'h10);
    checkOutput("post-abort lat", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/storage_controller.md
STORAGE_CONTROLLER -- requirements
Module: storage_controller

Interface
REQ-001 The parameter list SHALL be, one per line:
- SRAM_WORDS, default 2048, internal SRAM depth in 32-bit words.
- SPI_CLK_DIV, default 2, clk cycles per SCK period (even, >=2).
- READ_OPCODE, default 8'h03, external flash read command.
REQ-002 The port list SHALL be, one per line:
- clk, input, 1, single clock; all logic is posedge clk.
- rst, input, 1, reset; asynchronous and active-high.
- memory_access, input, 1, request valid (level).
- memory_is_writing, input, 1, 1 = write, 0 = read.
- addr, input, 32, word address.
- d_in, input, 32, write data.
- mem_be, input, 4, byte enables; bit n covers d_in[8n+7:8n].
- d_out, output, 32, read data.
- out_valid, output, 1, access complete.
- set_programming_mode, input, 1, selects SPI passthrough (level).
- external_storage_spi_cs_n / _sck / _mosi, output, 1 each, SPI master to flash.
- external_storage_spi_miso, input, 1, flash data.
- programming_spi_cs_n / _sck / _mosi, input, 1 each, external programmer.
- programming_spi_miso, output, 1, data to programmer.

Function
REQ-003 When set_programming_mode=1, external cs_n/sck/mosi SHALL equal the programming_spi_* inputs combinationally, and programming_spi_miso SHALL equal external_storage_spi_miso.
REQ-004 While set_programming_mode=1, the FSM SHALL be held in IDLE (aborting any transfer) and out_valid SHALL be 0.
REQ-005 When set_programming_mode=0, programming_spi_miso SHALL be 0 and the external SPI pins SHALL be driven by the controller.
REQ-006 Address decode:
- addr < SRAM_WORDS (0x000-0x7FF) selects the SRAM, indexed by addr[10:0].
- Any other address selects the external flash.
REQ-007 SRAM write: a request accepted in IDLE SHALL update only the enabled bytes at the next posedge; out_valid SHALL rise the following cycle.
REQ-008 SRAM read: d_out SHALL hold the addressed word and out_valid=1 one cycle after acceptance.
REQ-009 Writes to the flash region SHALL be ignored (read-only) and acknowledged like SRAM writes.
REQ-010 Flash read SHALL be an SPI mode 0 transaction:
- cs_n low for the whole transfer; SCK idles low.
- MOSI changes after SCK falling edges; MISO is sampled on SCK rising edges; MSB first.
- Sequence: READ_OPCODE (8 bits), then addr[23:0] (24 bits), then 32 data bits shifted into d_out.
- cs_n returns high after the last bit.
REQ-011 The FSM states SHALL be IDLE, SRAM_ACC, SPI_CMD (32 bits out), SPI_DATA (32 bits in) and DONE.
REQ-012 The FSM transitions SHALL be:
- IDLE -> SRAM_ACC or SPI_CMD on memory_access.
- SPI_CMD -> SPI_DATA after 32 SCK rising edges.
- SPI_DATA -> DONE after 32 SCK rising edges.
- SRAM_ACC -> DONE after one cycle.
- DONE -> IDLE when memory_access=0.
REQ-013 out_valid SHALL be 1 only in DONE; d_out SHALL be stable in DONE; addr, d_in, mem_be and memory_is_writing SHALL be latched at acceptance.
REQ-014 A new request SHALL be accepted in IDLE only; changes to inputs mid-transfer SHALL be ignored.
REQ-015 Flash read latency SHALL be 64*SPI_CLK_DIV + 2 cycles from acceptance to out_valid.

Reset
REQ-016 While rst=1, the controller SHALL hold:
- FSM in IDLE; out_valid=0; d_out=0.
- cs_n=1, sck=0, mosi=0 (when not in programming mode).
- Shift registers and bit counters cleared.
REQ-017 A reset asserted mid-transfer SHALL abort the transfer immediately, with no out_valid.
REQ-018 SRAM contents SHALL not be reset.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, READ_OPCODE, and the SRAM address width (11).
REQ-020 The SPI shifter and SCK divider SHALL be one sub-module, spi_read_master; the SRAM array, decode, FSM and passthrough mux SHALL live in storage_controller.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Passthrough: programming mode=1; drive all 8 cs_n/sck/mosi combinations -> external pins match within the same cycle; miso 0/1 -> programming_spi_miso 0/1.
- SRAM sweep: for i=0..0x7FF, write d_in=i with mem_be=4'hF, then read i -> out_valid, d_out=i.
- Byte enables: write 0xFFFFFFFF, then 0x12345678 with mem_be=4'b0101 -> readback 0xFF34FF78.
- Flash read: addr 0x00001001 -> MOSI bits 0x03 then 0x001001; MISO 0x12345678 -> d_out=0x12345678, out_valid=1; cs_n returns high.
- Reset mid-flash-read after 10 SCK edges -> cs_n=1, out_valid=0; next SRAM read completes normally.
